// File: rtl/fifo_wptr_full_ctrl.sv
// fifo_wptr_full_ctrl
//   Write-domain pointer and status controller for a dual-clock FIFO.
//   Keeps the binary and Gray write pointers. Synchronises the read-domain
//   Gray pointer into wclk. Derives full, almost-full, fill level and a
//   sticky overflow flag from the two pointers.
//
// Ports
//   wclk, wrst_n   write clock, async active-low reset
//   winc           write request from the producer
//   rptr_gray      read pointer (Gray), asynchronous to wclk
//   woverflow_clr  clears woverflow (a same-edge set wins)
//   waddr          storage write address (from the binary pointer)
//   wclk_en        storage write enable (= winc & ~wfull)
//   wfull          registered full flag
//   wptr_gray      registered Gray write pointer, sent to the read domain
//   walmost_full   registered: free entries <= AFULL_MARGIN
//   wlevel         registered fill level seen from the write side, 0..DEPTH
//   woverflow      sticky: a write was attempted while full
module fifo_wptr_full_ctrl #(
  parameter int ADDR_SIZE    = 8,
  parameter int AFULL_MARGIN = 4,
  parameter int SYNC_STAGES  = 2
) (
  input  logic                 wclk,
  input  logic                 wrst_n,
  input  logic                 winc,
  input  logic [ADDR_SIZE:0]   rptr_gray,
  input  logic                 woverflow_clr,
  output logic [ADDR_SIZE-1:0] waddr,
  output logic                 wclk_en,
  output logic                 wfull,
  output logic [ADDR_SIZE:0]   wptr_gray,
  output logic                 walmost_full,
  output logic [ADDR_SIZE:0]   wlevel,
  output logic                 woverflow
);

  localparam int PW = ADDR_SIZE + 1;
  localparam logic [PW-1:0] AF_THRESH = PW'((1 << ADDR_SIZE) - AFULL_MARGIN);

  logic [PW-1:0] wbin_q, wbin_d;
  logic [PW-1:0] wgray_q, wgray_d;
  logic [PW-1:0] lvl_d;
  logic          wfull_q, wfull_d;
  logic          wafull_q, wafull_d;
  logic [PW-1:0] wlevel_q;
  logic          wovf_q, wovf_d;
  logic          accept;

  // Plain flop chain for the synchroniser. Nothing combinational sits between
  // the stages, so only Gray-coded (single-bit-change) values cross.
  logic [SYNC_STAGES-1:0][PW-1:0] sync_q;
  logic [PW-1:0] rq_gray, rq_bin;

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) sync_q <= '0;
    else         sync_q <= {sync_q[SYNC_STAGES-2:0], rptr_gray};
  end

  assign rq_gray = sync_q[SYNC_STAGES-1];

  // Gray to binary: bit i is the XOR of all Gray bits from the MSB down to i.
  always_comb begin
    rq_bin = '0;
    for (int i = 0; i < PW; i++) rq_bin[i] = ^(rq_gray >> i);
  end

  assign accept  = winc & ~wfull_q;
  assign wclk_en = accept;
  assign waddr   = wbin_q[ADDR_SIZE-1:0];

  always_comb begin
    wbin_d   = wbin_q + PW'(accept);
    wgray_d  = (wbin_d >> 1) ^ wbin_d;
    // Modular difference. It stays in 0..DEPTH because a stale read pointer
    // only ever lags the true one.
    lvl_d    = wbin_d - rq_bin;
    // Full: the pointers are one lap apart. In Gray code that means the two
    // MSBs are inverted and the rest are equal. Requires ADDR_SIZE >= 2.
    wfull_d  = (wgray_d == {~rq_gray[PW-1:PW-2], rq_gray[PW-3:0]});
    wafull_d = (lvl_d >= AF_THRESH);
    // A set on the same edge as a clear takes priority.
    wovf_d   = (winc & wfull_q) | (wovf_q & ~woverflow_clr);
  end

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      wbin_q   <= '0;
      wgray_q  <= '0;
      wfull_q  <= 1'b0;
      wafull_q <= 1'b0;
      wlevel_q <= '0;
      wovf_q   <= 1'b0;
    end else begin
      wbin_q   <= wbin_d;
      wgray_q  <= wgray_d;
      wfull_q  <= wfull_d;
      wafull_q <= wafull_d;
      wlevel_q <= lvl_d;
      wovf_q   <= wovf_d;
    end
  end

  assign wfull        = wfull_q;
  assign wptr_gray    = wgray_q;
  assign walmost_full = wafull_q;
  assign wlevel       = wlevel_q;
  assign woverflow    = wovf_q;

endmodule

// File: tb/tb_fifo_wptr_full_ctrl.sv
module tb_fifo_wptr_full_ctrl;
  localparam int AW  = 4;
  localparam int PW  = AW + 1;
  localparam int D   = 1 << AW;
  localparam int AFM = 4;
  localparam int SS  = 2;

  logic          wclk = 1'b0;
  logic          wrst_n = 1'b1;
  logic          winc = 1'b0;
  logic [PW-1:0] rptr_gray = '0;
  logic          woverflow_clr = 1'b0;
  logic [AW-1:0] waddr;
  logic          wclk_en, wfull, walmost_full, woverflow;
  logic [PW-1:0] wptr_gray, wlevel;

  fifo_wptr_full_ctrl #(.ADDR_SIZE(AW), .AFULL_MARGIN(AFM), .SYNC_STAGES(SS)) dut (
    .wclk(wclk), .wrst_n(wrst_n), .winc(winc), .rptr_gray(rptr_gray),
    .woverflow_clr(woverflow_clr), .waddr(waddr), .wclk_en(wclk_en),
    .wfull(wfull), .wptr_gray(wptr_gray), .walmost_full(walmost_full),
    .wlevel(wlevel), .woverflow(woverflow)
  );

  always #5 wclk = ~wclk;

  int errors = 0;
  int checks = 0;

  // Reference model in terms of counts: writes accepted, reads issued, and
  // the read count as seen SS edges later through the synchroniser.
  int m_wcnt, m_rcnt, m_level;
  int m_hist[SS];
  bit m_full, m_afull, m_ovf;

  function automatic logic [PW-1:0] to_gray(int n);
    logic [PW-1:0] b;
    b = PW'(n);
    return b ^ (b >> 1);
  endfunction

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic m_reset();
    m_wcnt = 0; m_rcnt = 0; m_level = 0;
    for (int i = 0; i < SS; i++) m_hist[i] = 0;
    m_full = 0; m_afull = 0; m_ovf = 0;
  endtask

  // Called just after a negedge: drive, check combinational outputs, take one
  // posedge, update the model, check registered outputs at the next negedge.
  task automatic step(input bit w, input bit r, input bit c);
    int rq;
    bit acc;
    if (r && m_rcnt < m_wcnt) m_rcnt++;
    winc = w; woverflow_clr = c; rptr_gray = to_gray(m_rcnt);
    #1;
    chk("wclk_en", 32'(wclk_en), 32'(w && !m_full));
    chk("waddr", 32'(waddr), 32'(m_wcnt % D));
    @(posedge wclk);
    acc   = w && !m_full;
    m_ovf = (w && m_full) || (m_ovf && !c);
    m_wcnt += int'(acc);
    rq = m_hist[SS-1];
    for (int i = SS-1; i > 0; i--) m_hist[i] = m_hist[i-1];
    m_hist[0] = m_rcnt;
    m_level = m_wcnt - rq;
    m_full  = (m_level == D);
    m_afull = (m_level >= D - AFM);
    @(negedge wclk);
    chk("wptr_gray", 32'(wptr_gray), 32'(to_gray(m_wcnt)));
    chk("wlevel", 32'(wlevel), 32'(m_level));
    chk("wfull", 32'(wfull), 32'(m_full));
    chk("walmost_full", 32'(walmost_full), 32'(m_afull));
    chk("woverflow", 32'(woverflow), 32'(m_ovf));
  endtask

  task automatic do_reset();
    wrst_n = 1'b0;
    winc = 1'b0; woverflow_clr = 1'b0; rptr_gray = '0;
    m_reset();
    @(negedge wclk);
    wrst_n = 1'b1;
  endtask

  initial begin
    logic [PW-1:0] prev;
    int pw, pr;
    m_reset();
    #1 wrst_n = 1'b0;
    @(negedge wclk);
    @(negedge wclk);
    chk("rst_wfull", 32'(wfull), 0);
    chk("rst_wlevel", 32'(wlevel), 0);
    chk("rst_wptr", 32'(wptr_gray), 0);
    wrst_n = 1'b1;

    // Asynchronous reset mid-operation.
    repeat (5) step(1, 0, 0);
    #2 wrst_n = 1'b0;
    #1;
    chk("arst_wfull", 32'(wfull), 0);
    chk("arst_afull", 32'(walmost_full), 0);
    chk("arst_wlevel", 32'(wlevel), 0);
    chk("arst_wptr", 32'(wptr_gray), 0);
    chk("arst_waddr", 32'(waddr), 0);
    chk("arst_ovf", 32'(woverflow), 0);
    do_reset();

    // Fill with the read pointer parked at 0.
    for (int i = 0; i < 20; i++) begin
      step(1, 0, 0);
      if (i == 10) chk("afull_lvl11", 32'(walmost_full), 0);
      if (i == 11) chk("afull_lvl12", 32'(walmost_full), 1);
      if (i == 15) begin
        chk("fill_full", 32'(wfull), 1);
        chk("fill_lvl", 32'(wlevel), 16);
        chk("fill_gray", 32'(wptr_gray), 32'h18);
      end
      if (i == 16) chk("fill_ovf", 32'(woverflow), 1);
    end
    chk("fill_waddr_hold", 32'(waddr), 0);

    // Release: one read becomes visible three edges later.
    step(0, 1, 0);
    chk("rel_e1", 32'(wfull), 1);
    step(0, 0, 0);
    chk("rel_e2", 32'(wfull), 1);
    step(0, 0, 0);
    chk("rel_e3", 32'(wfull), 0);
    chk("rel_lvl", 32'(wlevel), 15);
    winc = 1'b1;
    #1 chk("rel_waddr", 32'(waddr), 0);
    chk("rel_wen", 32'(wclk_en), 1);
    step(1, 0, 0);

    // Overflow clear and the set-wins race.
    step(0, 0, 1);
    chk("ovf_clr", 32'(woverflow), 0);
    step(1, 0, 1);
    chk("ovf_race", 32'(woverflow), 1);
    step(0, 0, 1);
    chk("ovf_clr2", 32'(woverflow), 0);

    // Wrap: alternating write and read across two pointer laps.
    do_reset();
    for (int i = 0; i < 40; i++) begin
      prev = wptr_gray;
      step(1, 0, 0);
      chk("gray_1bit", 32'($countones(wptr_gray ^ prev)), 1);
      if (i == 15 || i == 31) chk("gray_msb_flip", 32'(wptr_gray[PW-1] ^ prev[PW-1]), 1);
      chk("wrap_lvl_rng", 32'(wlevel <= 2), 1);
      step(0, 1, 0);
      chk("wrap_lvl_rng", 32'(wlevel <= 2), 1);
    end

    // Random traffic in phases with different write/read bias.
    do_reset();
    for (int ph = 0; ph < 12; ph++) begin
      pw = $urandom_range(10, 90);
      pr = $urandom_range(10, 90);
      for (int i = 0; i < 200; i++) begin
        prev = wptr_gray;
        step($urandom_range(99) < pw, $urandom_range(99) < pr, $urandom_range(99) < 5);
        if (wptr_gray != prev) chk("rnd_gray_1bit", 32'($countones(wptr_gray ^ prev)), 1);
        chk("rnd_full_eq", 32'(wfull), 32'(wlevel == D));
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
